// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the
// programmable clock-enable divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam int DIV_MIN = 2;

  function automatic int half_up(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// clk_div_if: ratio configuration handshake between
// the configuration bus and the divider controller.
interface clk_div_if #(
  parameter int W = 4
);

  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, wrap detect and
// registered clk_out / tick generation.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         run,
  input  logic         load_div,
  input  logic [W-1:0] div,
  output logic         wrap,
  output logic [W-1:0] count,
  output logic         clk_out,
  output logic         tick
);

  logic [W-1:0] nxt;

  assign nxt  = count + 1'b1;
  assign wrap = (count == div - 1'b1);

  // load_div starts a fresh period; the high phase
  // is at least one cycle for every legal ratio.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (load_div) begin
      count   <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else begin
      count   <= nxt;
      clk_out <= (int'(nxt) < half_up(int'(div)));
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop sequencing and ratio
// handshake around clk_div_core.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int W           = 4,
  parameter int DIV_DEFAULT = 6,
  parameter int DIV_MAX     = 12
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         en,
  clk_div_if.slave     cfg,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] count_out,
  output logic [W-1:0] cur_div,
  output logic         running
);

  state_t       state;
  state_t       state_nx;
  logic         load;
  logic         run_nx;
  logic         wrap;
  logic         wrap_edge;
  logic         xfer;
  logic         legal;
  logic [W-1:0] pend;
  logic         pend_v;
  logic         err_q;

  assign running   = (state != IDLE);
  assign wrap_edge = running && wrap;
  assign xfer      = cfg.cfg_valid && !pend_v;
  assign legal     = (int'(cfg.cfg_div) >= DIV_MIN) &&
                     (int'(cfg.cfg_div) <= DIV_MAX);
  assign cfg.cfg_ready = !pend_v;
  assign cfg.cfg_err   = err_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A stop request only takes effect on a wrap, so
  // no phase is ever cut short.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          state_nx = en ? RUN : IDLE;
          load     = en;
        end else if (!en) begin
          state_nx = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (en) begin
          state_nx = RUN;
          load     = wrap;
        end else if (wrap) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign run_nx = (state_nx != IDLE);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cur_div <= W'(DIV_DEFAULT);
      pend    <= '0;
      pend_v  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= xfer && !legal;
      if (xfer && legal) begin
        if (!running || wrap_edge) begin
          cur_div <= cfg.cfg_div;
        end else begin
          pend   <= cfg.cfg_div;
          pend_v <= 1'b1;
        end
      end
      if (wrap_edge && pend_v) begin
        cur_div <= pend;
        pend_v  <= 1'b0;
      end
    end
  end

  clk_div_core #(
    .W (W)
  ) u_core (
    .clk      (clk),
    .reset_L  (reset_L),
    .run      (run_nx),
    .load_div (load),
    .div      (cur_div),
    .wrap     (wrap),
    .count    (count_out),
    .clk_out  (clk_out),
    .tick     (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed plus random stimulus
// against a period-level reference model.
module tb_clk_div_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         reset_L;
  logic         en;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] count_out;
  logic [W-1:0] cur_div;
  logic         running;

  clk_div_if #(.W(W)) bus ();

  clk_div_ctrl #(
    .W           (W),
    .DIV_DEFAULT (6),
    .DIV_MAX     (12)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .en        (en),
    .cfg       (bus.slave),
    .clk_out   (clk_out),
    .tick      (tick),
    .count_out (count_out),
    .cur_div   (cur_div),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // model: period position, ratio, pending ratio
  int m_pos;
  int m_div;
  int m_pend;
  bit m_run;
  bit m_err;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_div  = 6;
    m_pend = -1;
    m_run  = 0;
    m_err  = 0;
  endtask

  task automatic model_edge();
    bit xfer;
    bit legal;
    bit wrap;
    int cd;
    int nd;
    int np;
    if (!reset_L) begin
      model_reset();
      return;
    end
    cd    = int'(bus.cfg_div);
    xfer  = bus.cfg_valid && (m_pend < 0);
    legal = (cd >= 2) && (cd <= 12);
    wrap  = m_run && (m_pos == m_div - 1);
    m_err = xfer && !legal;
    nd = m_div;
    np = m_pend;
    if (xfer && legal) begin
      if (!m_run || wrap) nd = cd;
      else np = cd;
    end
    if (wrap && m_pend >= 0) begin
      nd = m_pend;
      np = -1;
    end
    if (!m_run) begin
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (wrap) begin
      m_pos = 0;
      if (!en) m_run = 0;
    end else begin
      m_pos++;
    end
    m_div  = nd;
    m_pend = np;
  endtask

  task automatic check_all();
    chk("running", int'(running), int'(m_run));
    chk("count_out", int'(count_out),
        m_run ? m_pos : 0);
    chk("clk_out", int'(clk_out),
        int'(m_run && (m_pos < (m_div + 1) / 2)));
    chk("tick", int'(tick), int'(m_run && m_pos == 0));
    chk("cur_div", int'(cur_div), m_div);
    chk("cfg_ready", int'(bus.cfg_ready),
        int'(m_pend < 0));
    chk("cfg_err", int'(bus.cfg_err), int'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < 40 && m_pos != p; k++) step();
    chk("sync_pos", int'(count_out), p);
  endtask

  task automatic offer(input int d);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = W'(d);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  // asynchronous reset pulse between clock edges
  task automatic async_reset();
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset_L       = 1'b0;
    en            = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    step();
    step();
    reset_L = 1'b1;
    step();

    en = 1'b1;
    repeat (14) step();

    wait_pos(2);
    offer(5);
    repeat (16) step();

    offer(1);
    offer(13);
    repeat (6) step();

    offer(6);
    repeat (12) step();
    wait_pos(1);
    en = 1'b0;
    repeat (8) step();
    en = 1'b1;
    repeat (8) step();
    wait_pos(2);
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (10) step();

    wait_pos(m_div - 1);
    offer(4);
    repeat (10) step();

    wait_pos(0);
    offer(9);
    chk("pre_rst_clk_out", int'(clk_out), 1);
    async_reset();
    repeat (4) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      bus.cfg_valid = ($urandom_range(0, 3) == 0);
      bus.cfg_div   = W'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time programmable clock-enable divider controller. Generates a divided, near-50%-duty clk_out and a period-start tick from clk.
- Sequences start/stop and divide-ratio changes so that every period is complete and glitch-free. Never truncates a high or low phase.
- Sits between the configuration bus and the divider datapath; replaces fixed-ratio divider instances where the ratio must change at run time.

Parameters:
- W, 4, width of the divide ratio and count registers; must hold DIV_MAX.
- DIV_DEFAULT, 6, divide ratio loaded at reset.
- DIV_MAX, 12, largest legal ratio. DIV_MIN is fixed at 2 in the package.

Ports:
- clk  in  1  system clock
- reset_L  in  1  reset
- en  in  1  level; 1 = run divider, 0 = stop at end of current period
- cfg_valid  in  1  new ratio offered
- cfg_div  in  W  requested divide ratio N
- cfg_ready  out  1  controller can accept cfg
- cfg_err  out  1  one-cycle pulse: offered ratio illegal, rejected
- clk_out  out  1  divided clock (registered)
- tick  out  1  one-cycle pulse on first clk of each period (registered)
- count_out  out  W  position in current period, 0..cur_div-1
- cur_div  out  W  ratio of the period in progress
- running  out  1  1 while a period is in progress

Behaviour:
- Reset: reset_L is asynchronous, active-low; clock is clk. While reset_L=0, all outputs are forced to their reset values.
  - Reset values: clk_out=0, tick=0, count_out=0, cur_div=DIV_DEFAULT, running=0, cfg_ready=1, cfg_err=0.
  - state=IDLE; any pending ratio is discarded.
- States: IDLE, RUN, STOP_PEND.
- Period rule: in RUN or STOP_PEND, count steps 0..cur_div-1 and then wraps.
  - clk_out=1 for count < ceil(cur_div/2), else 0. N=6 gives 3 high / 3 low; N=5 gives 3/2; N=2 gives 1/1.
  - clk_out and tick are registered alongside count, so they align with count_out in the same cycle.
  - tick=1 exactly when count_out=0 and running=1.
- IDLE -> RUN: en sampled 1 at an edge; at that same edge count<=0, clk_out<=1, tick<=1, running<=1. Latency is one edge.
- RUN -> STOP_PEND: en sampled 0.
- STOP_PEND:
  - en sampled 1 before the wrap returns to RUN with no gap or extra tick.
  - At the wrap edge, goes to IDLE with count=0, clk_out=0, running=0.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready at an edge.
  - Illegal cfg_div (<2 or >DIV_MAX) is consumed; cfg_err=1 for the next cycle; no other state changes.
  - Legal in IDLE: cur_div<=cfg_div at that edge.
  - Legal in RUN/STOP_PEND, not at the wrap edge: stored in pend and cfg_ready<=0. Applied at the next wrap (the next period uses the new ratio). cfg_ready<=1 at that same wrap edge.
  - Legal at a wrap edge (count=cur_div-1): applied directly to the period starting at that edge; cfg_ready stays 1.
  - A ratio equal to cur_div is legal and follows the same rules.
- Stop with pending ratio: the ratio is applied at the stop wrap; cur_div is updated on entering IDLE.
- Never: a phase shorter than its nominal length; a ratio change mid-period; two ticks closer than cur_div cycles.

Decomposition:
- Package clk_div_pkg contains:
  - state enum {IDLE, RUN, STOP_PEND}
  - DIV_MIN=2
  - function half_up(N) = ceil(N/2)
- Sub-module clk_div_core: count register, wrap detect, clk_out/tick compare. Inputs are run, load_div and div. Outputs are wrap, count and clk_out.
- clk_div_ctrl holds the FSM, pend register and handshake logic.

Test Plan:
- Reset, en=1 -> tick every 6 cycles; clk_out pattern 111000 repeating; count_out 0..5; cur_div=6.
- RUN, offer cfg_div=5 at count_out=2 -> cfg_ready=0 until the wrap; the current period completes 6 cycles; the next periods are 11100; cur_div=5; cfg_ready=1.
- Offer cfg_div=1, then cfg_div=13 -> cfg_err one-cycle pulse each; cur_div and period unchanged; cfg_ready stays 1.
- en=0 at count_out=1 (N=6) -> count reaches 5; next cycle clk_out=0, running=0, count_out=0. en=0->1 again before the wrap -> continuous, no gap.
- cfg_div=4 offered exactly at count_out=cur_div-1 -> the next period is 1100; cfg_ready never drops.
- reset_L low during the high phase -> clk_out=0 and running=0 immediately (asynchronous); cur_div=6 even if a pending ratio existed.
